riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
Control sequencer for the multi-cycle RV64 datapath variant. It steps each instruction through fetch / decode / execute / memory / writeback over several `clock` cycles, driving the same strobe set the single-cycle datapath uses (RegWrite, MemRead, MemWrite, MemtoReg, Branch-derived PC write). It waits on a memory ready handshake, traps on illegal opcodes or memory timeout, and keeps cycle and retired-instruction counters for CPI measurement.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a MemRead/MemWrite may wait for mem_ready before trapping; range 1..255.
- CNT_W, 64: width of cycle_count and instr_count.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- opcode  in  7  IR[6:0] from the instruction register.
- funct3  in  3  IR[14:12].
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  register write-data select: 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00 PC, 01 rs1, 10 OldPC.
- ALUSrcB  out  2  00 rs2, 01 const 4, 10 imm.
- ALUOp  out  2  00 add, 01 sub (compare), 10 funct-decoded.
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target).
- busy  out  1  high in every state except IDLE, HALT and TRAP.
- halted  out  1  high in HALT.
- trap  out  1  high in TRAP.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout; 00 otherwise.
- state  out  4  current state encoding, for debug.
- cycle_count  out  CNT_W  cycles spent while busy.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- Reset (async, active-high): state = IDLE, both counters = 0, timeout counter = 0, trap_cause = 00. All strobes and flags read 0 while in reset.
- Strobes are combinational from state, plus mem_ready in memory states and alu_zero/funct3 in BRANCH. State, counters and trap_cause are registered.
- IDLE: all strobes 0. start → FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - On mem_ready: IRWrite=1, PCWrite=1 (PCSource=0), next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target → ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1110011 → HALT
  - anything else → TRAP with cause 01.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10 → ALU_WB.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=10 → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0 → FETCH; retires.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00 → MEM_RD if the load opcode, MEM_WR if the store opcode.
- MEM_RD: MemRead=1, IorD=1; on mem_ready → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1 → FETCH; retires.
- MEM_WR: MemWrite=1, IorD=1; on mem_ready → FETCH; retires.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSource=1.
  - PCWrite = (funct3==000 & alu_zero) | (funct3==001 & ~alu_zero).
  - Any other funct3 → TRAP with cause 01, PCWrite=0.
  - Otherwise → FETCH; retires whether taken or not.
- Memory timeout:
  - The timeout counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle mem_ready=0 in those states.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 → TRAP with cause 10.
  - mem_ready=1 on the final allowed cycle wins over the timeout.
- HALT and TRAP: sticky, all strobes 0. Only reset exits them; start is ignored.
- instr_count increments by 1 on each retiring transition. HALT (ecall) counts as retired on entry; TRAP does not.
- cycle_count increments every cycle busy=1. Both counters wrap modulo 2^CNT_W.
- start asserted while busy is ignored.
- Reset asserted mid-instruction aborts immediately. No partial write is held: strobes drop to 0 asynchronously.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum: IDLE=0, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALT, TRAP.
  - opcode constants.
  - ALUSrcA/ALUSrcB/ALUOp encodings.
  - trap cause codes.
- One natural sub-module, ctrl_timeout_counter: a loadable saturating counter with clear and expire outputs.

Test Plan:
- Reset, then start; opcode 0110011; mem_ready=1 in FETCH → sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH. RegWrite=1 for exactly 1 cycle; instr_count=1, cycle_count=4.
- Load with mem_ready delayed 3 cycles in MEM_RD → MemRead held 4 cycles; MEM_WB asserts MemtoReg=1 and RegWrite=1; instr_count increments once.
- BEQ: alu_zero=1 → PCWrite=1, PCSource=1 in BRANCH. BNE with alu_zero=1 → PCWrite=0. Both retire.
- Opcode 1111111 → TRAP after DECODE, trap_cause=01, busy=0. A following start has no effect; only reset clears it.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after 4 FETCH cycles, trap_cause=10, instr_count unchanged.
- Reset pulsed mid MEM_WR → outputs 0 immediately, state=IDLE, counters=0. Then ecall (1110011) → HALT, halted=1, instr_count=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control sequencer: states,
// opcodes, ALU operand/op selects and trap causes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        ALU_WB   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        HALT     = 4'd11,
        TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that sit on the memory ready handshake and are timeout-guarded.
    function automatic logic is_mem_wait(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_timeout_counter.sv
// Saturating wait counter; expire fires on the waiting cycle that would
// bring the count to LIMIT.
module ctrl_timeout_counter #(
    parameter int LIMIT = 16,
    parameter int W     = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != W'(LIMIT))
            count <= count + W'(1);
    end

    assign expire = inc && (count == W'(LIMIT - 1));

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV64 control sequencer: steps fetch/decode/execute/memory/
// writeback, traps on illegal opcodes or memory timeout, counts cycles/retires.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             busy,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_e     cur, nxt;
    logic       retire;
    logic [1:0] cause_set;
    logic       tmo_inc, tmo_expire;

    // Counting only while stalled; any other cycle clears, which covers
    // every entry into a waiting state.
    assign tmo_inc = is_mem_wait(cur) && !mem_ready;

    ctrl_timeout_counter #(.LIMIT(MEM_TIMEOUT), .W(8)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clr    (!tmo_inc),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur         <= IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            trap_cause  <= CAUSE_NONE;
        end else begin
            cur <= nxt;
            if (busy)
                cycle_count <= cycle_count + CNT_W'(1);
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if (cause_set != CAUSE_NONE)
                trap_cause <= cause_set;
        end
    end

    always_comb begin
        nxt       = cur;
        retire    = 1'b0;
        cause_set = CAUSE_NONE;
        case (cur)
            IDLE:     if (start) nxt = FETCH;
            FETCH: begin
                if (mem_ready)
                    nxt = DECODE;
                else if (tmo_expire) begin
                    nxt       = TRAP;
                    cause_set = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:               nxt = EXEC_R;
                    OP_I:               nxt = EXEC_I;
                    OP_LOAD, OP_STORE:  nxt = MEM_ADDR;
                    OP_BRANCH:          nxt = BRANCH;
                    OP_SYSTEM: begin
                        nxt    = HALT;
                        retire = 1'b1;
                    end
                    default: begin
                        nxt       = TRAP;
                        cause_set = CAUSE_ILLEGAL;
                    end
                endcase
            end
            EXEC_R, EXEC_I: nxt = ALU_WB;
            ALU_WB, MEM_WB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            MEM_ADDR: begin
                // Opcode changing under us after decode is treated as illegal.
                if (opcode == OP_LOAD)
                    nxt = MEM_RD;
                else if (opcode == OP_STORE)
                    nxt = MEM_WR;
                else begin
                    nxt       = TRAP;
                    cause_set = CAUSE_ILLEGAL;
                end
            end
            MEM_RD: begin
                if (mem_ready)
                    nxt = MEM_WB;
                else if (tmo_expire) begin
                    nxt       = TRAP;
                    cause_set = CAUSE_TIMEOUT;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end else if (tmo_expire) begin
                    nxt       = TRAP;
                    cause_set = CAUSE_TIMEOUT;
                end
            end
            BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end else begin
                    nxt       = TRAP;
                    cause_set = CAUSE_ILLEGAL;
                end
            end
            HALT, TRAP: nxt = cur;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALU_ADD;
        PCSource = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_FUNCT;
            end
            EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_FUNCT;
            end
            ALU_WB:   RegWrite = 1'b1;
            MEM_ADDR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                ALUOp    = ALU_SUB;
                PCSource = 1'b1;
                PCWrite  = (funct3 == F3_BEQ && alu_zero) || (funct3 == F3_BNE && !alu_zero);
            end
            default: ;
        endcase
    end

    assign busy   = (cur != IDLE) && (cur != HALT) && (cur != TRAP);
    assign halted = (cur == HALT);
    assign trap   = (cur == TRAP);
    assign state  = cur;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed + randomized bench for riscv_multicycle_ctrl; expectations come from
// an instruction-level model (per-class cycle and strobe budgets).
module tb_riscv_multicycle_ctrl;

    localparam int CNT_W = 64;
    localparam int TMO   = 4;

    logic             clock = 1'b0;
    logic             reset, start, alu_zero, mem_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [1:0]       ALUSrcA, ALUSrcB, ALUOp;
    logic             PCSource, busy, halted, trap;
    logic [1:0]       trap_cause;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycle_count, instr_count;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .busy(busy), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .state(state), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_cyc, exp_ins;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        logic [15:0] all;
        all = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, busy, 1'b0};
        check(tag, 64'(all), 64'd0);
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 beq, 5 bne. Entered with DUT in FETCH.
    task automatic run_instr(input int kind, input int fl, input int ml, input bit az, input bit rnd_start);
        bit mr[$];
        int n_regw, n_rd, n_wr, n_pcw, n_pcs, n_irw, n_m2r, n_busy;
        int e_regw, e_rd, e_wr, e_pcw, e_pcs, e_m2r;
        logic [6:0] ops [6];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011};
        opcode   = ops[kind];
        funct3   = (kind == 4) ? 3'b000 : (kind == 5) ? 3'b001 : 3'($urandom_range(0, 7));
        alu_zero = az;
        repeat (fl) mr.push_back(1'b0);
        mr.push_back(1'b1);
        mr.push_back(1'($urandom));
        case (kind)
            0, 1: begin mr.push_back(1'($urandom)); mr.push_back(1'($urandom)); end
            2: begin
                mr.push_back(1'($urandom));
                repeat (ml) mr.push_back(1'b0);
                mr.push_back(1'b1);
                mr.push_back(1'($urandom));
            end
            3: begin
                mr.push_back(1'($urandom));
                repeat (ml) mr.push_back(1'b0);
                mr.push_back(1'b1);
            end
            default: mr.push_back(1'($urandom));
        endcase
        {n_regw, n_rd, n_wr, n_pcw, n_pcs, n_irw, n_m2r, n_busy} = '0;
        foreach (mr[i]) begin
            mem_ready = mr[i];
            start     = rnd_start ? 1'($urandom) : 1'b0;
            @(negedge clock);
            n_regw += int'(RegWrite); n_rd += int'(MemRead); n_wr += int'(MemWrite);
            n_pcw += int'(PCWrite); n_pcs += int'(PCSource); n_irw += int'(IRWrite);
            n_m2r += int'(MemtoReg); n_busy += int'(busy);
            tick();
        end
        start = 1'b0;
        e_regw = (kind <= 2) ? 1 : 0;
        e_rd   = fl + 1 + ((kind == 2) ? ml + 1 : 0);
        e_wr   = (kind == 3) ? ml + 1 : 0;
        e_pcw  = 1 + (((kind == 4 && az) || (kind == 5 && !az)) ? 1 : 0);
        e_pcs  = (kind >= 4) ? 1 : 0;
        e_m2r  = (kind == 2) ? 1 : 0;
        exp_cyc += 64'(mr.size());
        exp_ins += 64'd1;
        check($sformatf("k%0d regwrite_cycles", kind), 64'(n_regw), 64'(e_regw));
        check($sformatf("k%0d memread_cycles", kind), 64'(n_rd), 64'(e_rd));
        check($sformatf("k%0d memwrite_cycles", kind), 64'(n_wr), 64'(e_wr));
        check($sformatf("k%0d pcwrite_cycles", kind), 64'(n_pcw), 64'(e_pcw));
        check($sformatf("k%0d pcsource_cycles", kind), 64'(n_pcs), 64'(e_pcs));
        check($sformatf("k%0d irwrite_cycles", kind), 64'(n_irw), 64'd1);
        check($sformatf("k%0d memtoreg_cycles", kind), 64'(n_m2r), 64'(e_m2r));
        check($sformatf("k%0d busy_cycles", kind), 64'(n_busy), 64'(mr.size()));
        check($sformatf("k%0d back_in_fetch", kind), 64'(state), 64'd1);
        check($sformatf("k%0d cycle_count", kind), cycle_count, exp_cyc);
        check($sformatf("k%0d instr_count", kind), instr_count, exp_ins);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        exp_cyc = '0; exp_ins = '0;
        #12;
        check("in_reset_state", 64'(state), 64'd0);
        check_quiet("in_reset_strobes");
        check("in_reset_cycles", cycle_count, 64'd0);
        @(negedge clock); reset = 1'b0; #1;
        check("idle_state", 64'(state), 64'd0);
        check_quiet("idle_strobes");
        check("idle_instr", instr_count, 64'd0);

        do_start();
        check("start_to_fetch", 64'(state), 64'd1);
        run_instr(0, 0, 0, 1'b0, 1'b0);
        check("rtype_cycle_count_is_4", cycle_count, 64'd4);
        run_instr(2, 0, 3, 1'b0, 1'b0);
        run_instr(4, 0, 0, 1'b1, 1'b0);
        run_instr(5, 0, 0, 1'b1, 1'b0);
        run_instr(3, TMO - 1, TMO - 1, 1'b0, 1'b0);
        run_instr(2, TMO - 1, TMO - 1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, TMO - 1)),
                      int'($urandom_range(0, TMO - 1)), 1'($urandom), 1'b1);

        // Illegal opcode.
        opcode = 7'b1111111; mem_ready = 1'b1;
        tick(); tick();
        exp_cyc += 64'd2;
        check("illegal_state_trap", 64'(state), 64'd12);
        check("illegal_trap_flag", 64'(trap), 64'd1);
        check("illegal_cause", 64'(trap_cause), 64'd1);
        check_quiet("illegal_strobes");
        do_start(); tick();
        check("trap_sticky_state", 64'(state), 64'd12);
        check("trap_cycle_frozen", cycle_count, exp_cyc);
        check("trap_instr_frozen", instr_count, exp_ins);

        reset = 1'b1; #1;
        check("reset_clears_trap", 64'(state), 64'd0);
        check("reset_clears_cause", 64'(trap_cause), 64'd0);
        check("reset_clears_instr", instr_count, 64'd0);
        @(negedge clock); reset = 1'b0;
        exp_cyc = '0; exp_ins = '0;

        // Memory timeout in FETCH.
        @(posedge clock); #1;
        mem_ready = 1'b0;
        do_start();
        repeat (TMO - 1) tick();
        check("timeout_still_fetch", 64'(state), 64'd1);
        tick();
        check("timeout_state_trap", 64'(state), 64'd12);
        check("timeout_cause", 64'(trap_cause), 64'd2);
        check("timeout_cycles", cycle_count, 64'(TMO));
        check("timeout_instr", instr_count, 64'd0);

        // Reset pulsed in the middle of a store.
        reset = 1'b1; #2; reset = 1'b0;
        do_start();
        opcode = 7'b0100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        @(negedge clock);
        check("memwr_active", 64'(MemWrite), 64'd1);
        #1 reset = 1'b1; #1;
        check("abort_memwrite_low", 64'(MemWrite), 64'd0);
        check_quiet("abort_strobes");
        check("abort_state_idle", 64'(state), 64'd0);
        check("abort_cycles", cycle_count, 64'd0);
        #1 reset = 1'b0;

        // ecall halts and retires.
        @(posedge clock); #1;
        do_start();
        opcode = 7'b1110011; mem_ready = 1'b1;
        tick(); tick();
        check("ecall_state_halt", 64'(state), 64'd11);
        check("ecall_halted", 64'(halted), 64'd1);
        check("ecall_instr", instr_count, 64'd1);
        check("ecall_cycles", cycle_count, 64'd2);
        do_start(); tick();
        check("halt_sticky", 64'(state), 64'd11);
        check("halt_not_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
